// File: rtl/cmp_share_arb_pkg.sv
// Shared types and constants for the comparator-sharing arbiter slice.
package cmp_share_pkg;

  localparam int CMP_WIDTH_DEF = 64;
  localparam int CMP_NREQ_DEF  = 4;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } slot_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_share_arb_if.sv
// Request/response bundle between clients and the shared comparator arbiter.
interface cmp_share_arb_if
  import cmp_share_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEF,
  parameter int NREQ  = CMP_NREQ_DEF,
  parameter int IDW   = clog2_min1(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_op1;
  logic [NREQ*WIDTH-1:0] req_op2;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic                  resp_eq;
  logic                  resp_lt;
  logic                  resp_ltu;

  modport master (
    output req_valid, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_eq, resp_lt, resp_ltu
  );

  modport slave (
    input  req_valid, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_eq, resp_lt, resp_ltu
  );

endinterface

// File: rtl/cmp_share_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping mod NREQ.
module cmp_rr_pick
  import cmp_share_pkg::*;
#(
  parameter int NREQ = CMP_NREQ_DEF,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_gnt
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int unsigned       off;
  int unsigned       sum;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr; the doubled copy supplies the wrap.
    dbl     = {req, req} >> ptr;
    rot     = dbl[NREQ-1:0];
    any_gnt = 1'b0;
    off     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_gnt && rot[i]) begin
        any_gnt = 1'b1;
        off     = i;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    gnt_idx = IDW'(sum);
    gnt_oh  = any_gnt ? (NREQ'(1) << sum) : '0;
  end

endmodule

// File: rtl/comparatortree.sv
// Combinational EQ / signed LT / unsigned LT over WIDTH-bit operands,
// built as a balanced reduction tree of per-bit (eq, lt) pairs.
module comparatortree #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  localparam int NLEAF = 1 << $clog2(WIDTH);

  logic [NLEAF-1:0] e;
  logic [NLEAF-1:0] l;

  always_comb begin
    e = '1;
    l = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      e[i] = ~(a[i] ^ b[i]);
      l[i] = ~a[i] & b[i];
    end
    // Higher-index node decides unless it is equal, then the lower one does.
    for (int unsigned s = 1; s < NLEAF; s = s * 2) begin
      for (int unsigned i = 0; i < NLEAF; i = i + 2 * s) begin
        l[i] = l[i+s] | (e[i+s] & l[i]);
        e[i] = e[i] & e[i+s];
      end
    end
  end

  assign eq  = e[0];
  assign ltu = l[0];
  // Differing sign bits decide the signed order; otherwise it matches unsigned.
  assign lt  = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : l[0];

endmodule

// File: rtl/cmp_share_arb.sv
// Shares one comparatortree among NREQ requesters through a round-robin
// arbiter and a single registered response slot.
module cmp_share_arb
  import cmp_share_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEF,
  parameter int NREQ  = CMP_NREQ_DEF
) (
  input  logic           clk,
  input  logic           reset,
  cmp_share_arb_if.slave bus
);

  localparam int IDW = clog2_min1(NREQ);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   ptr_nxt;

  logic [NREQ-1:0]  gnt_oh;
  logic [IDW-1:0]   gnt_idx;
  logic             any_gnt;
  logic             can_accept;
  logic             xfer;

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_ltu;

  logic [IDW-1:0]   resp_id_q;
  logic             resp_eq_q;
  logic             resp_lt_q;
  logic             resp_ltu_q;

  cmp_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign can_accept    = (state_q == S_EMPTY) || bus.resp_ready;
  assign bus.req_ready = (can_accept && any_gnt && !reset) ? gnt_oh : '0;
  assign xfer          = |(bus.req_valid & bus.req_ready);

  // Part-select mux: only the granted requester's operands reach the comparator.
  always_comb begin
    op1 = '0;
    op2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op1 = bus.req_op1[i*WIDTH +: WIDTH];
        op2 = bus.req_op2[i*WIDTH +: WIDTH];
      end
    end
  end

  comparatortree #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a   (op1),
    .b   (op2),
    .eq  (cmp_eq),
    .lt  (cmp_lt),
    .ltu (cmp_ltu)
  );

  always_comb begin
    state_d = state_q;
    ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    case (state_q)
      S_EMPTY: if (xfer) state_d = S_FULL;
      S_FULL:  if (bus.resp_ready && !xfer) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      rr_ptr     <= '0;
      resp_id_q  <= '0;
      resp_eq_q  <= 1'b0;
      resp_lt_q  <= 1'b0;
      resp_ltu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        rr_ptr     <= ptr_nxt;
        resp_id_q  <= gnt_idx;
        resp_eq_q  <= cmp_eq;
        resp_lt_q  <= cmp_lt;
        resp_ltu_q <= cmp_ltu;
      end
    end
  end

  assign bus.resp_valid = (state_q == S_FULL);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_eq    = resp_eq_q;
  assign bus.resp_lt    = resp_lt_q;
  assign bus.resp_ltu   = resp_ltu_q;

endmodule
